// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU in EX; stalls the pipe until the result is ready.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module ex_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  typedef enum logic [1:0] {S_IDLE, S_DZERO, S_ON, S_DONE} state_t;

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;   // dividend magnitude, shifts out MSBs and collects quotient bits
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_dsign, r_qsign, r_ready;
  logic [WIDTH-1:0] r_quo_o, r_rem_o;

  logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs, w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_qbit, w_dz, w_last;

  assign w_abs_dvd = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign w_abs_dvs = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
  assign w_dz      = (divisor_i == '0);
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = !w_dz && (w_abs_dvd < w_abs_dvs);
`endif

  always_comb begin
    w_nxt = r_state;
    if (annul_i) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
`ifdef DIV_EARLY_OUT_EN
          if (w_dz)         w_nxt = S_DZERO;
          else if (w_early) w_nxt = S_DONE;
          else              w_nxt = S_ON;
`else
          w_nxt = w_dz ? S_DZERO : S_ON;
`endif
        end
        S_DZERO: w_nxt = S_DONE;
        S_ON:    if (w_last) w_nxt = S_DONE;
        S_DONE:  if (!start_i) w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_dsign <= 1'b0;
      r_qsign <= 1'b0;
      r_ready <= 1'b0;
      r_quo_o <= '0;
      r_rem_o <= '0;
    end else begin
      r_state <= w_nxt;
      // ready lags DONE by one edge so the result registers settle first
      r_ready <= (r_state == S_DONE) && (w_nxt == S_DONE);
      if (!annul_i) begin
        case (r_state)
          S_IDLE: if (start_i) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_dz ? dividend_i : w_abs_dvd;
            r_dvs   <= w_abs_dvs;
            r_dsign <= signed_i && dividend_i[WIDTH-1];
            r_qsign <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_quo_o <= '0;
              r_rem_o <= dividend_i;
            end
`endif
          end
          S_DZERO: begin
            r_quo_o <= '1;
            r_rem_o <= r_dvd;
          end
          S_ON: begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            if (w_last) begin
              r_quo_o <= r_qsign ? -w_quo_nxt : w_quo_nxt;
              r_rem_o <= r_dsign ? -w_rem_nxt : w_rem_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign stallreq_o  = start_i & ~ready_o & ~annul_i;
  assign ready_o     = r_ready;
  assign quotient_o  = r_quo_o;
  assign remainder_o = r_rem_o;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: driver pushes expected results, monitor pops on each ready_o rise.
module tb_ex_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_i, signed_i, annul_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic         stallreq_o, ready_o;
  logic [W-1:0] quotient_o, remainder_o;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] sb_q[$];
  logic prev_rdy = 1'b0;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .stallreq_o(stallreq_o),
    .ready_o(ready_o), .quotient_o(quotient_o), .remainder_o(remainder_o)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare result on each rising ready_o
  always @(negedge clk) begin
    if (ready_o && !prev_rdy) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got q=%h r=%h expected no result", quotient_o, remainder_o);
      end else begin
        logic [2*W-1:0] e;
        e = sb_q.pop_front();
        chk("quotient", quotient_o, e[2*W-1:W]);
        chk("remainder", remainder_o, e[W-1:0]);
      end
    end
    prev_rdy = ready_o;
  end

  task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input int elat);
    int lat = 0;
    logic stall_ok = 1'b1;
    sb_q.push_back({eq, er});
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    #1 chk({name, "_stall0"}, W'(stallreq_o), W'(1));
    @(posedge clk);  // acceptance edge
    #1;
    // operands must be ignored after acceptance
    dividend_i = ~a; divisor_i = 32'h3; signed_i = ~sgn;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (ready_o) break;
      if (!stallreq_o) stall_ok = 1'b0;
    end
    chk({name, "_latency"}, W'(lat), W'(elat));
    chk({name, "_stall_held"}, W'(stall_ok), W'(1));
    chk({name, "_stall_off"}, W'(stallreq_o), W'(0));
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_ready_drop"}, W'(ready_o), W'(0));
    chk({name, "_q_hold"}, quotient_o, eq);
  endtask

  initial begin
    int seen;
    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #12;
    chk("rst_ready", W'(ready_o), W'(0));
    chk("rst_q", quotient_o, '0);
    chk("rst_r", remainder_o, '0);
    @(negedge clk); rst = 1'b1;

    do_div("u100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    do_div("s-100_7", 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   33);
    do_div("s100_-7", 1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          33);
    do_div("u5_0",    1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          2);
    do_div("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33);

    // annul mid-operation: no result may appear
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1 chk("annul_stall", W'(stallreq_o), W'(0));
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("annul_no_ready", W'(seen), W'(0));
    do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // reset mid-operation
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFFFFFF; divisor_i = 32'd1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_ready", W'(ready_o), W'(0));
    chk("rstmid_q", quotient_o, '0);
    chk("rstmid_r", remainder_o, '0);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("rstmid_no_ready", W'(seen), W'(0));

    do_div("u6_4", 1'b0, 32'd6, 32'd4, 32'd1, 32'd2, 33);
`ifdef DIV_EARLY_OUT_EN
    do_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1);
    do_div("s-3_10", 1'b1, 32'hFFFFFFFD, 32'd10, 32'd0, 32'hFFFFFFFD, 1);
`else
    do_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33);
    do_div("s-3_10", 1'b1, 32'hFFFFFFFD, 32'd10, 32'd0, 32'hFFFFFFFD, 33);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", W'(sb_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage. Serves DIV and DIVU.
- The EX stage launches an operation and holds the pipeline via a stall request until the result is ready.
- The quotient and remainder are then written to the HI/LO path carried on the EX-to-MEM bus.
- Supports signed and unsigned operands. Honours pipeline flush (annul).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a divide; held high by EX until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- annul_i  in  1  flush; abandons any in-flight operation.
- dividend_i  in  WIDTH  dividend (rs); sampled when start accepted.
- divisor_i  in  WIDTH  divisor (rt); sampled when start accepted.
- stallreq_o  out  1  stall request to the stall controller.
- ready_o  out  1  result valid.
- quotient_o  out  WIDTH  quotient, to LO.
- remainder_o  out  WIDTH  remainder, to HI.

Behaviour:
- Reset (rst=0, async): state=IDLE; counter=0; ready_o=0; quotient_o=0; remainder_o=0.
- States: IDLE, DZERO, ON, DONE.
- IDLE:
  - start_i=1 and annul_i=0 latches operands and signed_i.
  - Divisor==0 goes to DZERO; otherwise goes to ON with counter=0.
  - Signed mode latches the absolute values of both operands, plus the sign of the dividend and the XOR of the operand signs.
- ON:
  - Each cycle performs one iteration: shift the partial remainder left by 1 bit and bring in the next dividend MSB.
  - Trial subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set it to 0.
  - Counter increments each cycle. After iteration WIDTH (counter==WIDTH-1) go to DONE.
  - Sign fix-up when entering DONE, signed mode only:
    - quotient is negated if the operand signs differ;
    - remainder is negated if the dividend was negative.
- DZERO: one cycle, then DONE with quotient=all ones and remainder=dividend as supplied (no sign fix-up).
- DONE:
  - ready_o=1, and outputs hold the result.
  - Stays in DONE while start_i=1.
  - start_i=0 goes to IDLE next edge; ready_o=0 there, and outputs keep their last value.
- Latency:
  - normal: ready_o rises on the (WIDTH+1)th edge after the edge that accepted start (33 for WIDTH=32);
  - divide-by-zero: ready_o rises on the 2nd edge after acceptance.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
- annul_i=1 in any state goes to IDLE at the next edge. It clears ready_o and suppresses acceptance in that cycle.
- Changes on dividend_i/divisor_i/signed_i after acceptance are ignored.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient=0x80000000, remainder=0. This is a natural result of magnitude arithmetic with WIDTH-bit wrap and needs no special case.
- Arithmetic:
  - partial remainder is WIDTH+1 bits wide for the trial subtract;
  - negation is two's complement, modulo 2^WIDTH.
- Reset asserted mid-operation aborts immediately. No ready_o is produced for the lost operation.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, when the divisor is nonzero and |dividend| < |divisor| (magnitudes compared after the signed abs), go directly to DONE at the next edge.
  - Result: quotient=0; remainder=original dividend (sign preserved).
  - ready_o rises at edge 1 after acceptance.
- Undefined: such operations take the full WIDTH-iteration path with identical results.

Test Plan:
- Unsigned 100/7, start held -> stallreq_o=1 for 33 cycles; ready_o at edge 33; quotient=14, remainder=2. Drop start -> IDLE, ready_o=0.
- Signed 0xFFFFFF9C(-100)/7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Then signed 100/0xFFFFFFF9(-7) -> quotient=0xFFFFFFF2, remainder=2.
- Unsigned 5/0 -> ready_o at edge 2; quotient=0xFFFFFFFF, remainder=5.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Start 100/7, annul_i pulse at cycle 10 -> ready_o never asserts, state IDLE. Next 9/3 -> quotient=3, remainder=0 at edge 33.
- Start 0xFFFFFFFF/1 unsigned, rst low at cycle 5 -> outputs 0 immediately. After release, 6/4 -> quotient=1, remainder=2. With DIV_EARLY_OUT_EN, 3/10 -> ready_o at edge 1, quotient=0, remainder=3.
